// File: rtl/alu_seq_mult_param_if.sv
// Execute-stage bus for alu_seq_mult_param: request/operands in, result/status out.
// The controller raises start with alu_op/a/b; the request is taken on a rising edge
// while busy is low, and done pulses for exactly one cycle when result/flags are valid.
interface alu_seq_mult_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] product_hi;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             zero;
  logic             dbg_state;

  modport master (
    output start, alu_op, a, b,
    input  result, product_hi, busy, done, overflow, zero, dbg_state
  );

  modport slave (
    input  start, alu_op, a, b,
    output result, product_hi, busy, done, overflow, zero, dbg_state
  );
endinterface

// File: rtl/alu_seq_mult_param.sv
// WIDTH-bit ALU with a sequential shift-add multiplier (one bit per cycle).
// Optional macro MULT_SIGNED_EN turns op 111 into a signed multiply (replacing NOR).
module alu_seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  alu_seq_mult_param_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_product_hi;
  logic               r_done;
  logic               r_ovf;
  logic               r_zero;

  logic               w_accept;
  logic               w_last;
  logic               w_is_mult;
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum_ext;
  logic               w_c_msb;
  logic               w_ovf_add;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ovf;
  logic [WIDTH:0]     w_acc_add;
  logic [WIDTH-1:0]   w_hi_n;
  logic [WIDTH-1:0]   w_lo_n;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;

  assign w_accept = bus.start && (r_state == S_IDLE);
  assign w_last   = (r_state == S_MUL) && (r_cnt == CNT_W'(1));

  // One adder for ADD/SUB/SLT; SUB and SLT feed ~b with carry-in 1.
  assign w_sub     = (bus.alu_op == 3'b010) || (bus.alu_op == 3'b100);
  assign w_b_eff   = w_sub ? ~bus.b : bus.b;
  assign w_sum_ext = {1'b0, bus.a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
  assign w_c_msb   = bus.a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum_ext[WIDTH-1];
  assign w_ovf_add = w_c_msb ^ w_sum_ext[WIDTH];

  // Shift-add step: conditional add keeps the carry, then {carry,hi,lo} >> 1.
  assign w_acc_add = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_mcand}) : {1'b0, r_hi};
  assign w_hi_n    = w_acc_add[WIDTH:1];
  assign w_lo_n    = {w_acc_add[0], r_lo[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic w_signed_op;
  logic r_neg;

  assign w_signed_op = (bus.alu_op == 3'b111);
  assign w_is_mult   = (bus.alu_op == 3'b011) || w_signed_op;
  // Most-negative input maps to magnitude 2^(WIDTH-1), which fits unsigned.
  assign w_op_a = (w_signed_op && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign w_op_b = (w_signed_op && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
  assign w_prod = r_neg ? (~{w_hi_n, w_lo_n} + (2*WIDTH)'(1)) : {w_hi_n, w_lo_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end
  end
`else
  assign w_is_mult = (bus.alu_op == 3'b011);
  assign w_op_a    = bus.a;
  assign w_op_b    = bus.b;
  assign w_prod    = {w_hi_n, w_lo_n};
`endif

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (bus.alu_op)
      3'b000: w_alu_res = bus.a & bus.b;
      3'b001: w_alu_res = bus.a | bus.b;
      3'b010: begin
        w_alu_res = w_sum_ext[WIDTH-1:0];
        w_alu_ovf = w_ovf_add;
      end
      3'b100: begin
        w_alu_res = {{(WIDTH-1){1'b0}}, w_sum_ext[WIDTH-1] ^ w_ovf_add};
        w_alu_ovf = w_ovf_add;
      end
      3'b101: begin
        w_alu_res = w_sum_ext[WIDTH-1:0];
        w_alu_ovf = w_ovf_add;
      end
      3'b110: w_alu_res = bus.a ^ bus.b;
`ifndef MULT_SIGNED_EN
      3'b111: w_alu_res = ~(bus.a | bus.b);
`endif
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mult) w_state_n = S_MUL;
      S_MUL:   if (w_last) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_mcand      <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_result     <= '0;
      r_product_hi <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_is_mult) begin
          r_mcand <= w_op_a;
          r_hi    <= '0;
          r_lo    <= w_op_b;
          r_cnt   <= CNT_W'(WIDTH);
        end else begin
          r_result     <= w_alu_res;
          r_product_hi <= '0;
          r_ovf        <= w_alu_ovf;
          r_zero       <= (w_alu_res == '0);
          r_done       <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_hi  <= w_hi_n;
        r_lo  <= w_lo_n;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_result     <= w_prod[WIDTH-1:0];
          r_product_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_ovf        <= 1'b0;
          r_zero       <= (w_prod[WIDTH-1:0] == '0);
          r_done       <= 1'b1;
        end
      end
    end
  end

  assign bus.result     = r_result;
  assign bus.product_hi = r_product_hi;
  assign bus.busy       = (r_state == S_MUL);
  assign bus.done       = r_done;
  assign bus.overflow   = r_ovf;
  assign bus.zero       = r_zero;
  assign bus.dbg_state  = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_seq_mult_param.sv
// Directed bench for alu_seq_mult_param (WIDTH=32): expected responses are queued at
// issue time and a negedge monitor pops/compares them whenever done is seen.
module tb_alu_seq_mult_param;
  localparam int W = 32;
  localparam int EW = 2 * W + 2;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_SUB = 3'b010, OP_MUL = 3'b011,
                         OP_SLT = 3'b100, OP_ADD = 3'b101, OP_XOR = 3'b110, OP_111 = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_mult_param_if #(.WIDTH(W)) ifc ();

  alu_seq_mult_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed as {result, product_hi, overflow, zero}.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done actual=1 required=0 result=%h", ifc.result);
      end else begin
        check("done_response", {ifc.result, ifc.product_hi, ifc.overflow, ifc.zero},
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ifc.start  = 1'b1;
    ifc.alu_op = op;
    ifc.a      = a;
    ifc.b      = b;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.a     = W'($urandom);
    ifc.b     = W'($urandom);
    ifc.alu_op = 3'($urandom_range(0, 7));
  endtask

  // Issue one request from idle and measure negedges until done plus busy-high count.
  // done is expected at negedge 1 for logic ops and at negedge W+1 (busy for W) for MULT.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic eo, input logic ez, input int exp_n, input int exp_busy);
    int n;
    int nb;
    bit seen;
    @(negedge clk);
    exp_q.push_back({er, eh, eo, ez});
    drive_req(op, a, b);
    n = 0;
    nb = 0;
    seen = 0;
    while (!seen && n < 2 * W + 8) begin
      @(negedge clk);
      n++;
      if (ifc.busy) nb++;
      if (ifc.done) seen = 1;
    end
    check({name, "_latency"}, EW'(n), EW'(exp_n));
    check({name, "_busy_cycles"}, EW'(nb), EW'(exp_busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    ifc.start  = 1'b0;
    ifc.alu_op = 3'b000;
    ifc.a      = '0;
    ifc.b      = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ifc.result, ifc.product_hi, ifc.overflow, ifc.zero},
          '0);
    check("reset_busy_done", EW'({ifc.busy, ifc.done, ifc.dbg_state}), '0);
    rst = 1'b0;

    // Logic ops: done one cycle after accept, busy never set.
    do_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, '0, 1'b1, 1'b0, 1, 0);
    do_op("sub_zero", OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, '0, 1'b0, 1'b1, 1, 0);
    do_op("slt_pos",  OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, '0, 1'b1, 1'b1, 1, 0);
    do_op("slt_neg",  OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, '0, 1'b0, 1'b0, 1, 0);

    do_op("mul_max",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE,
          1'b0, 1'b0, W + 1, W);
    // product_hi must drop back to 0 on a logic op.
    do_op("and",      OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, '0, 1'b0, 1'b0, 1, 0);
    do_op("or",       OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, '0, 1'b0, 1'b0, 1, 0);
    do_op("xor",      OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, '0, 1'b0, 1'b0, 1, 0);
    do_op("sub_wrap", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, '0, 1'b0, 1'b0, 1, 0);
    do_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, '0, 1'b1, 1'b0, 1, 0);
    do_op("mul_zero", OP_MUL, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, '0, 1'b0, 1'b1, W + 1, W);

`ifdef MULT_SIGNED_EN
    do_op("mults_neg", OP_111, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF,
          1'b0, 1'b0, W + 1, W);
    do_op("mults_min", OP_111, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000,
          1'b0, 1'b1, W + 1, W);
    do_op("mults_pos", OP_111, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0006, 32'h0000_0000,
          1'b0, 1'b0, W + 1, W);
`else
    do_op("nor",      OP_111, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, '0, 1'b0, 1'b0, 1, 0);
`endif

    // Start during MULT is ignored; a start in the done cycle is taken back-to-back.
    @(negedge clk);
    exp_q.push_back({32'h0001_2340, 32'h0, 1'b0, 1'b0});
    drive_req(OP_MUL, 32'h0000_1234, 32'h0000_0010);
    repeat (9) @(negedge clk);
    drive_req(OP_ADD, 32'h0000_0001, 32'h0000_0001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.done && n < 2 * W);
    check("mid_mul_done_seen", EW'(ifc.done), EW'(1));
    exp_q.push_back({32'h0000_0007, 32'h0, 1'b0, 1'b0});
    drive_req(OP_ADD, 32'h0000_0003, 32'h0000_0004);
    @(negedge clk);
    check("b2b_done", EW'({ifc.done, ifc.busy}), EW'(2'b10));
    @(negedge clk);
    check("done_single_pulse", EW'(ifc.done), EW'(0));

    // Reset mid-MULT: outputs clear immediately, no done pulse follows.
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0});
    drive_req(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) @(negedge clk);
    check("pre_reset_busy", EW'(ifc.busy), EW'(1));
    check("aborted_pending", EW'(exp_q.size()), EW'(1));
    rst = 1'b1;
    #1;
    check("async_reset_clear", {ifc.result, ifc.product_hi, ifc.overflow, ifc.zero}, '0);
    check("async_reset_busy_done", EW'({ifc.busy, ifc.done}), '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("no_done_after_abort_busy", EW'(ifc.busy), EW'(0));

    do_op("mul_6x7", OP_MUL, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 32'h0,
          1'b0, 1'b0, W + 1, W);

    repeat (4) @(negedge clk);
    check("held_result", {ifc.result, ifc.product_hi, ifc.overflow, ifc.zero},
          {32'h0000_002A, 32'h0, 1'b0, 1'b0});
    check("queue_drained", EW'(exp_q.size()), EW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
